// File: rtl/jtag_ir_decode_reg_if.sv
// TAP-side signal bundle for the JTAG instruction register with opcode decode.
// master drives the TAP flags and serial data; slave is the IR itself.
interface jtag_ir_decode_reg_if #(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned NUM_DR     = 8
);
    logic                  test_logic_reset;
    logic                  capture_ir;
    logic                  shift_ir;
    logic                  update_ir;
    logic                  tdi;
    logic [DATA_WIDTH-3:0] status;
    logic                  tdo;
    logic [DATA_WIDTH-1:0] opcode;
    logic [NUM_DR-1:0]     dr_sel;
    logic                  bypass_sel;
    logic                  invalid;
    logic                  length_err;

    modport master (
        output test_logic_reset, capture_ir, shift_ir, update_ir, tdi, status,
        input  tdo, opcode, dr_sel, bypass_sel, invalid, length_err
    );

    modport slave (
        input  test_logic_reset, capture_ir, shift_ir, update_ir, tdi, status,
        output tdo, opcode, dr_sel, bypass_sel, invalid, length_err
    );
endinterface

// File: rtl/jtag_ir_decode_reg.sv
// JTAG instruction register with shadow opcode and registered one-hot DR select.
// Optional shift-length check enabled by defining JTAG_IR_LENGTH_CHECK_EN.
module jtag_ir_decode_reg #(
    parameter int unsigned           DATA_WIDTH   = 5,
    parameter int unsigned           NUM_DR       = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_OPCODE = {DATA_WIDTH{1'b1}}
) (
    input logic               clock,
    input logic               reset,
    jtag_ir_decode_reg_if.slave ir
);

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

    typedef struct packed {
        logic [DATA_WIDTH-1:0] opcode;
        logic [NUM_DR-1:0]     dr_sel;
        logic                  bypass_sel;
        logic                  invalid;
    } decode_t;

    // Anything outside 0..NUM_DR-1 that is not BYPASS falls back to BYPASS and flags invalid.
    function automatic decode_t decode(input logic [DATA_WIDTH-1:0] value);
        decode_t d;
        d.opcode     = ALL_ONES;
        d.dr_sel     = '0;
        d.bypass_sel = 1'b1;
        d.invalid    = 1'b0;
        if (value != ALL_ONES) begin
            if (value < DATA_WIDTH'(NUM_DR)) begin
                d.opcode     = value;
                d.bypass_sel = 1'b0;
                for (int unsigned k = 0; k < NUM_DR; k++) begin
                    d.dr_sel[k] = (value == DATA_WIDTH'(k));
                end
            end else begin
                d.invalid = 1'b1;
            end
        end
        return d;
    endfunction

    logic                  rst_any;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  update_ok;
    decode_t               rst_dec;
    decode_t               upd_dec;
    logic [DATA_WIDTH-1:0] opcode_q;
    logic [NUM_DR-1:0]     dr_sel_q;
    logic                  bypass_sel_q;
    logic                  invalid_q;

    assign rst_any = reset | ir.test_logic_reset;
    assign rst_dec = decode(RESET_OPCODE);
    assign upd_dec = decode(shift_reg);

    // Capture/shift path; update always sees the value from before this edge.
    always_ff @(posedge clock) begin
        if (rst_any) begin
            shift_reg <= '0;
        end else if (ir.capture_ir) begin
            shift_reg <= {ir.status, 2'b01};
        end else if (ir.shift_ir) begin
            shift_reg <= {ir.tdi, shift_reg[DATA_WIDTH-1:1]};
        end
    end

`ifdef JTAG_IR_LENGTH_CHECK_EN
    localparam int unsigned          CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DATA_WIDTH);

    logic [CNT_W-1:0] shift_cnt;
    logic             length_err_q;

    // Saturating count of bits shifted since the last capture.
    always_ff @(posedge clock) begin
        if (rst_any) begin
            shift_cnt <= '0;
        end else if (ir.capture_ir) begin
            shift_cnt <= '0;
        end else if (ir.shift_ir && (shift_cnt < CNT_MAX)) begin
            shift_cnt <= shift_cnt + CNT_W'(1);
        end
    end

    assign update_ok = (shift_cnt >= CNT_MAX);

    always_ff @(posedge clock) begin
        if (rst_any) begin
            length_err_q <= 1'b0;
        end else if (ir.update_ir) begin
            length_err_q <= ~update_ok;
        end
    end

    assign ir.length_err = length_err_q;
`else
    assign update_ok     = 1'b1;
    assign ir.length_err = 1'b0;
`endif

    // Shadow register and decoded selects commit together on the update edge.
    always_ff @(posedge clock) begin
        if (rst_any) begin
            opcode_q     <= rst_dec.opcode;
            dr_sel_q     <= rst_dec.dr_sel;
            bypass_sel_q <= rst_dec.bypass_sel;
            invalid_q    <= 1'b0;
        end else if (ir.update_ir && update_ok) begin
            opcode_q     <= upd_dec.opcode;
            dr_sel_q     <= upd_dec.dr_sel;
            bypass_sel_q <= upd_dec.bypass_sel;
            invalid_q    <= upd_dec.invalid;
        end
    end

    assign ir.tdo        = shift_reg[0];
    assign ir.opcode     = opcode_q;
    assign ir.dr_sel     = dr_sel_q;
    assign ir.bypass_sel = bypass_sel_q;
    assign ir.invalid    = invalid_q;

endmodule

// File: tb/tb_jtag_ir_decode_reg.sv
// Scoreboard bench for jtag_ir_decode_reg: every cycle the model's expected outputs are
// queued as stimulus is driven and popped for comparison after the edge.
module tb_jtag_ir_decode_reg;

    localparam int unsigned      DW   = 5;
    localparam int unsigned      NDR  = 8;
    localparam int unsigned      CW   = $clog2(DW + 1);
    localparam logic [DW-1:0]    ONES = {DW{1'b1}};

    logic clock = 1'b0;
    logic reset;

    jtag_ir_decode_reg_if #(.DATA_WIDTH(DW), .NUM_DR(NDR)) bus ();

    jtag_ir_decode_reg #(
        .DATA_WIDTH  (DW),
        .NUM_DR      (NDR),
        .RESET_OPCODE(ONES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ir   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic           tdo;
        logic [DW-1:0]  opcode;
        logic [NDR-1:0] dr_sel;
        logic           bypass_sel;
        logic           invalid;
        logic           length_err;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    string         phase  = "init";
    logic [DW-1:0] m_sr;
    logic [CW-1:0] m_cnt;
    exp_t          m_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, expv);
        end
    endtask

    function automatic exp_t decode_model(input logic [DW-1:0] v, input exp_t prev);
        exp_t e;
        e            = prev;
        e.length_err = 1'b0;
        if (v == ONES) begin
            e.opcode = ONES; e.dr_sel = '0; e.bypass_sel = 1'b1; e.invalid = 1'b0;
        end else if (v < DW'(NDR)) begin
            e.opcode = v; e.dr_sel = NDR'(1) << v; e.bypass_sel = 1'b0; e.invalid = 1'b0;
        end else begin
            e.opcode = ONES; e.dr_sel = '0; e.bypass_sel = 1'b1; e.invalid = 1'b1;
        end
        return e;
    endfunction

    task automatic cycle();
        exp_t e;
        if (reset || bus.test_logic_reset) begin
            m_sr  = '0;
            m_cnt = '0;
            m_out = decode_model(ONES, m_out);
        end else begin
            if (bus.update_ir) begin
`ifdef JTAG_IR_LENGTH_CHECK_EN
                if (m_cnt < CW'(DW)) m_out.length_err = 1'b1;
                else
`endif
                m_out = decode_model(m_sr, m_out);
            end
            if (bus.capture_ir) begin
                m_sr  = {bus.status, 2'b01};
                m_cnt = '0;
            end else if (bus.shift_ir) begin
                m_sr = {bus.tdi, m_sr[DW-1:1]};
                if (m_cnt < CW'(DW)) m_cnt = m_cnt + CW'(1);
            end
        end
        e     = m_out;
        e.tdo = m_sr[0];
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("tdo",        32'(bus.tdo),        32'(e.tdo));
        check("opcode",     32'(bus.opcode),     32'(e.opcode));
        check("dr_sel",     32'(bus.dr_sel),     32'(e.dr_sel));
        check("bypass_sel", 32'(bus.bypass_sel), 32'(e.bypass_sel));
        check("invalid",    32'(bus.invalid),    32'(e.invalid));
        check("length_err", 32'(bus.length_err), 32'(e.length_err));
    endtask

    task automatic capture(input logic [DW-3:0] st);
        bus.status     = st;
        bus.capture_ir = 1'b1;
        cycle();
        bus.capture_ir = 1'b0;
    endtask

    task automatic shift(input logic [DW-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.shift_ir = 1'b1;
            bus.tdi      = v[i];
            cycle();
        end
        bus.shift_ir = 1'b0;
        bus.tdi      = 1'b0;
    endtask

    task automatic update();
        bus.update_ir = 1'b1;
        cycle();
        bus.update_ir = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] v);
        capture(bus.status);
        shift(v, DW);
        update();
    endtask

    initial begin
        logic [DW-1:0] scan_pat;
        reset                = 1'b1;
        bus.test_logic_reset = 1'b0;
        bus.capture_ir       = 1'b0;
        bus.shift_ir         = 1'b0;
        bus.update_ir        = 1'b0;
        bus.tdi              = 1'b0;
        bus.status           = '0;
        m_out                = '0;

        phase = "reset";
        cycle();
        cycle();
        reset = 1'b0;
        check("opcode_c", 32'(bus.opcode), 32'h1f);
        check("bypass_c", 32'(bus.bypass_sel), 32'h1);
        check("dr_sel_c", 32'(bus.dr_sel), 32'h00);
        check("tdo_c", 32'(bus.tdo), 32'h0);
        check("invalid_c", 32'(bus.invalid), 32'h0);

        phase = "scan";
        capture(3'b101);
        scan_pat = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            check("tdo_seq", 32'(bus.tdo), 32'(scan_pat[i]));
            bus.shift_ir = 1'b1;
            cycle();
        end
        bus.shift_ir = 1'b0;

        phase = "valid";
        load(5'b00011);
        check("opcode_c", 32'(bus.opcode), 32'h3);
        check("dr_sel_c", 32'(bus.dr_sel), 32'h08);

        phase = "invalid";
        load(5'b01010);
        check("opcode_c", 32'(bus.opcode), 32'h1f);
        check("invalid_c", 32'(bus.invalid), 32'h1);
        check("dr_sel_c", 32'(bus.dr_sel), 32'h00);

        phase = "short";
        load(5'b00011);
        capture(3'b101);
        shift(5'b00000, 3);
        update();
`ifdef JTAG_IR_LENGTH_CHECK_EN
        check("opcode_c", 32'(bus.opcode), 32'h3);
        check("length_err_c", 32'(bus.length_err), 32'h1);
`else
        check("opcode_c", 32'(bus.opcode), 32'h2);
        check("length_err_c", 32'(bus.length_err), 32'h0);
`endif
        load(5'b00001);
        check("opcode_c2", 32'(bus.opcode), 32'h1);
        check("length_err_c2", 32'(bus.length_err), 32'h0);

        phase = "tlr";
        capture(3'b101);
        shift(5'b11111, 2);
        bus.test_logic_reset = 1'b1;
        cycle();
        bus.test_logic_reset = 1'b0;
        check("opcode_c", 32'(bus.opcode), 32'h1f);
        check("tdo_c", 32'(bus.tdo), 32'h0);
        update();
`ifdef JTAG_IR_LENGTH_CHECK_EN
        check("opcode_c2", 32'(bus.opcode), 32'h1f);
        check("length_err_c", 32'(bus.length_err), 32'h1);
`else
        check("opcode_c2", 32'(bus.opcode), 32'h0);
        check("dr_sel_c", 32'(bus.dr_sel), 32'h01);
`endif

        phase = "upd_shift";
        capture(3'b101);
        shift(5'b00100, 5);
        bus.shift_ir  = 1'b1;
        bus.tdi       = 1'b1;
        bus.update_ir = 1'b1;
        cycle();
        bus.shift_ir  = 1'b0;
        bus.tdi       = 1'b0;
        bus.update_ir = 1'b0;
        check("opcode_c", 32'(bus.opcode), 32'h4);
        check("dr_sel_c", 32'(bus.dr_sel), 32'h10);
        update();
        check("invalid_c", 32'(bus.invalid), 32'h1);

        phase = "cap_upd";
        capture(3'b000);
        shift(5'b00110, 5);
        bus.capture_ir = 1'b1;
        bus.update_ir  = 1'b1;
        cycle();
        bus.capture_ir = 1'b0;
        bus.update_ir  = 1'b0;
        check("opcode_c", 32'(bus.opcode), 32'h6);
        check("dr_sel_c", 32'(bus.dr_sel), 32'h40);
        update();
`ifdef JTAG_IR_LENGTH_CHECK_EN
        check("opcode_c2", 32'(bus.opcode), 32'h6);
        check("length_err_c", 32'(bus.length_err), 32'h1);
`else
        check("opcode_c2", 32'(bus.opcode), 32'h1);
        check("length_err_c", 32'(bus.length_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
